clk_div_bank: RTL and testbench
===============================

// Module: clk_div_bank
// PURPOSE
//   Lock-qualified, run-time programmable clock-enable/divided-clock bank fed by the PLL output.
//   Waits for a stable PLL lock, then produces NUM_CH independent divided clocks and one-cycle
//   enables. Per-channel divisors are reprogrammable via a valid/ready port without glitches.
//   Sits directly behind the SB_PLL40 wrapper and replaces its fixed full/half-rate outputs.
// PARAMETERS
//   NUM_CH      2   number of output channels (1..16)
//   DIV_W       8   divisor width; legal divisor 0..2^DIV_W-1
//   DEFAULT_DIV 2   divisor loaded into every channel at reset
//   LOCK_WAIT   16  consecutive synced-lock cycles required before RUN (>=1)
//   CH_W        max(1,$clog2(NUM_CH))  channel-select width (derived, do not override)
// PORTS
//   clock_in   in   1            PLL global output clock; sole clock
//   reset      in   1            synchronous, active-high reset
//   locked     in   1            PLL LOCK, asynchronous to clock_in
//   cfg_valid  in   1            divisor update request
//   cfg_ready  out  1            update accepted when cfg_valid & cfg_ready
//   cfg_ch     in   CH_W         target channel
//   cfg_div    in   DIV_W        new divisor
//   cfg_err    out  1            one-cycle pulse: accepted request had cfg_ch >= NUM_CH
//   ready      out  1            high while in RUN
//   ce_out     out  NUM_CH       per-channel one-cycle enable, once per period
//   clk_out    out  NUM_CH       per-channel divided clock (fabric signal, registered)
// BEHAVIOUR
//   Reset: state=WAIT_LOCK; ready, ce_out, clk_out, cfg_err=0; divisors=DEFAULT_DIV;
//     pending flags cleared; stability count=0. Reset overrides every other event.
//   locked passes through a 2-FF synchroniser (lk_s). Nothing downstream uses raw locked.
//   FSM: WAIT_LOCK --lk_s=1--> STABLE (count=1) ; STABLE counts while lk_s=1,
//     reaching LOCK_WAIT -> RUN ; lk_s=0 in STABLE or RUN -> WAIT_LOCK, count=0.
//   ready is registered: 1 exactly in RUN cycles.
//   Outside RUN: channel counters=0, ce_out=0, clk_out=0.
//   Channel i, effective N = (div<2) ? 1 : div; counter c runs 0..N-1, wraps to 0.
//     First RUN cycle has c=0. ce_out[i]=1 when c==0. clk_out[i]=1 when c < ceil(N/2).
//     => N=1: ce_out and clk_out constantly 1. N=2: 50% duty. Odd N: high one cycle longer.
//   Config: cfg_ready = ~pending[cfg_ch] (1 for out-of-range cfg_ch).
//     Accept with valid cfg_ch -> shadow=cfg_div, pending=1.
//     Accept with cfg_ch>=NUM_CH -> no state change; cfg_err=1 next cycle.
//     In RUN, pending applies at the wrap: cycle where c==N-1 loads div, so next c=0 starts
//     a full new-N period. No truncated or stretched period.
//     Not in RUN (or leaving RUN), pending applies on the next cycle.
//   Simultaneous accept and wrap on the same channel: wrap uses old shadow (none pending) and
//     the new value waits for the following wrap.
//   Lock loss with a pending update: update applied, outputs low, restart on relock.
//   Arithmetic: counters DIV_W bits, compare only, no overflow (c < N <= 2^DIV_W-1).
// TESTING
//   1 reset 3 cyc, locked=1, LOCK_WAIT=16, DEFAULT_DIV=2 -> ready rises 18 cyc after reset
//     release; ce_out[0] 1,0,1,0..; clk_out[0] 50%.
//   2 locked low 1 cyc at STABLE count 10 -> ready delayed a full 16 more;
//     locked low in RUN -> ready, ce_out, clk_out 0 within 3 cyc; relock repeats #1 timing.
//   3 ch1 div 4, write 7 at c=1 -> cfg_ready[ch1 sel]=0 until wrap; then periods of 7,
//     clk_out high 4 / low 3, ce_out spacing 4 then 7, no runt pulse.
//   4 two back-to-back writes to ch0 (5 then 3) -> second stalls until first applied;
//     periods go 2 -> 5 -> 3.
//   5 NUM_CH=3, cfg_ch=3 -> accepted, cfg_err single pulse, all divisors unchanged;
//     div=0 and div=1 -> ce_out, clk_out constant 1 in RUN.
//   6 reset asserted mid-RUN with pending update -> next cycle all outputs 0,
//     divisors=DEFAULT_DIV, pending cleared.

Source files
------------

// File: rtl/clk_div_bank.sv
// clk_div_bank: lock-qualified bank of run-time programmable clock dividers.
// After the PLL lock has stayed stable for LOCK_WAIT cycles, each channel
// produces a one-cycle enable and a registered divided clock. Divisors are
// reprogrammed through a valid/ready port. A new divisor takes effect only
// at a period boundary, so the outputs never show a runt or stretched period.

module clk_div_bank #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int LOCK_WAIT   = 16,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              locked,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic              ready,
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] clk_out
);

  localparam int CNT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_WAIT - 1);
  localparam logic [DIV_W-1:0] DEF_DIV   = DIV_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  // Divisors 0 and 1 both mean "divide by one".
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    eff_div = (d < DIV_W'(2)) ? DIV_W'(1) : d;
  endfunction

  // Number of high cycles in one period: ceil(n/2).
  function automatic logic [DIV_W:0] high_len(input logic [DIV_W-1:0] n);
    logic [DIV_W:0] sum;
    sum      = {1'b0, n} + {{DIV_W{1'b0}}, 1'b1};
    high_len = sum >> 1;
  endfunction

  // Lock synchroniser
  logic lk_meta_r;
  logic lk_s;

  // Lock qualification FSM
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] stab_cnt_r;
  logic [CNT_W-1:0] stab_cnt_nxt_s;
  logic             run_now_s;
  logic             run_nxt_s;

  // Channel state
  logic [DIV_W-1:0] div_r        [NUM_CH];
  logic [DIV_W-1:0] shadow_r     [NUM_CH];
  logic [DIV_W-1:0] cnt_r        [NUM_CH];
  logic [DIV_W-1:0] div_nxt_s    [NUM_CH];
  logic [DIV_W-1:0] shadow_nxt_s [NUM_CH];
  logic [DIV_W-1:0] cnt_nxt_s    [NUM_CH];
  logic [DIV_W-1:0] n_cur_s      [NUM_CH];
  logic [DIV_W-1:0] n_nxt_s      [NUM_CH];
  logic [NUM_CH-1:0] pend_r;
  logic [NUM_CH-1:0] pend_nxt_s;
  logic [NUM_CH-1:0] wrap_s;
  logic [NUM_CH-1:0] acc_s;
  logic [NUM_CH-1:0] apply_s;
  logic [NUM_CH-1:0] ce_nxt_s;
  logic [NUM_CH-1:0] clk_nxt_s;

  // Config port decode
  logic ch_in_range_s;
  logic cfg_ready_s;

  // Two-flop synchroniser for the asynchronous PLL lock input.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      lk_meta_r <= 1'b0;
      lk_s      <= 1'b0;
    end else begin
      lk_meta_r <= locked;
      lk_s      <= lk_meta_r;
    end
  end

  // Next-state logic: require LOCK_WAIT consecutive locked cycles before RUN.
  always_comb begin
    state_nxt_s    = state_r;
    stab_cnt_nxt_s = stab_cnt_r;
    case (state_r)
      WAIT_LOCK: begin
        if (lk_s) begin
          if (LOCK_WAIT <= 1) begin
            state_nxt_s    = RUN;
            stab_cnt_nxt_s = '0;
          end else begin
            state_nxt_s    = STABLE;
            stab_cnt_nxt_s = CNT_W'(1);
          end
        end else begin
          stab_cnt_nxt_s = '0;
        end
      end
      STABLE: begin
        if (!lk_s) begin
          state_nxt_s    = WAIT_LOCK;
          stab_cnt_nxt_s = '0;
        end else if (stab_cnt_r >= LOCK_LAST) begin
          state_nxt_s    = RUN;
          stab_cnt_nxt_s = '0;
        end else begin
          stab_cnt_nxt_s = stab_cnt_r + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_nxt_s    = WAIT_LOCK;
          stab_cnt_nxt_s = '0;
        end else begin
          stab_cnt_nxt_s = '0;
        end
      end
      default: begin
        state_nxt_s    = WAIT_LOCK;
        stab_cnt_nxt_s = '0;
      end
    endcase
  end

  // State register and registered ready flag (high exactly in RUN cycles).
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_r    <= WAIT_LOCK;
      stab_cnt_r <= '0;
      ready      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      stab_cnt_r <= stab_cnt_nxt_s;
      ready      <= (state_nxt_s == RUN);
    end
  end

  // Config handshake: ready mirrors the target channel's free shadow slot.
  always_comb begin
    ch_in_range_s = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
    cfg_ready_s   = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_ready_s = (ch_in_range_s && (cfg_ch == CH_W'(i))) ? ~pend_r[i] : cfg_ready_s;
    end
  end

  assign cfg_ready = cfg_ready_s;

  // Per-channel counter, divisor update and next output values.
  always_comb begin
    run_now_s = (state_r == RUN);
    run_nxt_s = (state_nxt_s == RUN);
    for (int i = 0; i < NUM_CH; i++) begin
      n_cur_s[i] = eff_div(div_r[i]);
      wrap_s[i]  = run_now_s && (cnt_r[i] == (n_cur_s[i] - DIV_W'(1)));
      acc_s[i]   = cfg_valid && ch_in_range_s && (cfg_ch == CH_W'(i)) && !pend_r[i];
      // A pending divisor lands at the period boundary, or immediately when
      // the counter is idle (outside RUN, entering RUN or leaving RUN).
      apply_s[i] = pend_r[i] && (!run_now_s || !run_nxt_s || wrap_s[i]);

      div_nxt_s[i]    = apply_s[i] ? shadow_r[i] : div_r[i];
      shadow_nxt_s[i] = acc_s[i] ? cfg_div : shadow_r[i];
      if (acc_s[i]) begin
        pend_nxt_s[i] = 1'b1;
      end else if (apply_s[i]) begin
        pend_nxt_s[i] = 1'b0;
      end else begin
        pend_nxt_s[i] = pend_r[i];
      end

      if (!run_nxt_s || !run_now_s || wrap_s[i]) begin
        cnt_nxt_s[i] = '0;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + DIV_W'(1);
      end

      n_nxt_s[i]   = eff_div(div_nxt_s[i]);
      ce_nxt_s[i]  = run_nxt_s && (cnt_nxt_s[i] == '0);
      clk_nxt_s[i] = run_nxt_s && ({1'b0, cnt_nxt_s[i]} < high_len(n_nxt_s[i]));
    end
  end

  // Channel registers and registered enable / divided-clock outputs.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_r[i]    <= DEF_DIV;
        shadow_r[i] <= DEF_DIV;
        cnt_r[i]    <= '0;
      end
      pend_r  <= '0;
      ce_out  <= '0;
      clk_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_r[i]    <= div_nxt_s[i];
        shadow_r[i] <= shadow_nxt_s[i];
        cnt_r[i]    <= cnt_nxt_s[i];
      end
      pend_r  <= pend_nxt_s;
      ce_out  <= ce_nxt_s;
      clk_out <= clk_nxt_s;
    end
  end

  // Error pulse for an accepted request aimed at a non-existent channel.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_valid && !ch_in_range_s;
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed testbench for clk_div_bank (NUM_CH=3, DIV_W=8, DEFAULT_DIV=2, LOCK_WAIT=16).
// Edge numbering: edge 1 is the first rising edge with reset low; with locked
// held high, RUN (ready=1, channel counters at 0) starts at edge 18.

module tb_clk_div_bank;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 8;
  localparam int CH_W   = 2;

  logic              clock_in = 1'b0;
  logic              reset    = 1'b1;
  logic              locked   = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch   = 2'd0;
  logic [DIV_W-1:0]  cfg_div  = 8'd0;
  logic              cfg_err;
  logic              ready;
  logic [NUM_CH-1:0] ce_out;
  logic [NUM_CH-1:0] clk_out;

  int n_cmp = 0;
  int n_err = 0;

  clk_div_bank #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(2), .LOCK_WAIT(16)
  ) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .locked   (locked),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_err  (cfg_err),
    .ready    (ready),
    .ce_out   (ce_out),
    .clk_out  (clk_out)
  );

  always #5 clock_in = ~clock_in;

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  // 3 reset cycles with locked high; returns just after the last reset edge.
  task automatic start_reset();
    reset = 1'b1; locked = 1'b1; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; locked = 1'b0; cfg_valid = 1'b0;
    repeat (3) tick();
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b exp 0", ready); end
    n_cmp++; if (ce_out !== 3'b000) begin n_err++; $display("FAIL rst_ce got %b exp 000", ce_out); end
    n_cmp++; if (clk_out !== 3'b000) begin n_err++; $display("FAIL rst_clk got %b exp 000", clk_out); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL rst_cfg_err got %b exp 0", cfg_err); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_cfg_ready got %b exp 1", cfg_ready); end
  endtask

  task automatic test_lock_timing();
    logic exp_b;
    start_reset();
    for (int e = 1; e <= 18; e++) begin
      tick();
      if (e == 17) begin
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL t1_ready_e17 got %b exp 0", ready); end
        n_cmp++; if (ce_out !== 3'b000) begin n_err++; $display("FAIL t1_ce_e17 got %b exp 000", ce_out); end
      end
    end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL t1_ready_e18 got %b exp 1", ready); end
    for (int k = 0; k < 4; k++) begin
      exp_b = ((k % 2) == 0);
      n_cmp++; if (ce_out[0] !== exp_b) begin n_err++; $display("FAIL t1_ce0 k=%0d got %b exp %b", k, ce_out[0], exp_b); end
      n_cmp++; if (clk_out[0] !== exp_b) begin n_err++; $display("FAIL t1_clk0 k=%0d got %b exp %b", k, clk_out[0], exp_b); end
      tick();
    end
  endtask

  task automatic test_lock_glitch();
    start_reset();
    // lk_s is low for the one cycle in which STABLE holds count 10.
    for (int e = 1; e <= 29; e++) begin
      tick();
      if (e == 10) locked = 1'b0;
      if (e == 11) locked = 1'b1;
      if (e == 18) begin
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL t2_ready_e18 got %b exp 0", ready); end
      end
      if (e == 28) begin
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL t2_ready_e28 got %b exp 0", ready); end
      end
    end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL t2_ready_e29 got %b exp 1", ready); end
    // Lock loss in RUN: two sync stages, then the FSM drops out.
    locked = 1'b0;
    tick(); tick();
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL t2_loss_ready_2 got %b exp 1", ready); end
    tick();
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL t2_loss_ready_3 got %b exp 0", ready); end
    n_cmp++; if (ce_out !== 3'b000) begin n_err++; $display("FAIL t2_loss_ce got %b exp 000", ce_out); end
    n_cmp++; if (clk_out !== 3'b000) begin n_err++; $display("FAIL t2_loss_clk got %b exp 000", clk_out); end
    repeat (3) tick();
    locked = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      tick();
      if (e == 17) begin
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL t2_relock_e17 got %b exp 0", ready); end
      end
    end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL t2_relock_e18 got %b exp 1", ready); end
    n_cmp++; if (ce_out !== 3'b111) begin n_err++; $display("FAIL t2_relock_ce got %b exp 111", ce_out); end
    n_cmp++; if (clk_out !== 3'b111) begin n_err++; $display("FAIL t2_relock_clk got %b exp 111", clk_out); end
  endtask

  task automatic test_reprogram();
    logic [11:0] ce_exp;
    logic [11:0] clk_exp;
    // ch1: N=4 for e18..e21, then N=7 from e22
    ce_exp  = 12'b1000_1000000_1;
    clk_exp = 12'b1100_1111000_1;
    start_reset();
    tick();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd4;
    #1;
    n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL t3_pre_ready got %b exp 1", cfg_ready); end
    tick();
    cfg_valid = 1'b0;
    repeat (16) tick();
    for (int k = 0; k < 12; k++) begin
      n_cmp++; if (ce_out[1] !== ce_exp[11-k]) begin n_err++; $display("FAIL t3_ce1 k=%0d got %b exp %b", k, ce_out[1], ce_exp[11-k]); end
      n_cmp++; if (clk_out[1] !== clk_exp[11-k]) begin n_err++; $display("FAIL t3_clk1 k=%0d got %b exp %b", k, clk_out[1], clk_exp[11-k]); end
      if (k == 1) begin
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd7;
        #1;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL t3_ready_k1 got %b exp 1", cfg_ready); end
      end
      if (k == 2 || k == 3) begin
        cfg_valid = 1'b0;
        #1;
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL t3_ready_k%0d got %b exp 0", k, cfg_ready); end
      end
      if (k == 4) begin
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL t3_ready_k4 got %b exp 1", cfg_ready); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] ce_exp;
    logic [10:0] clk_exp;
    // ch0 periods: 2 (e18), 5 (e20), 3 (e25)
    ce_exp  = 11'b10_10000_100_1;
    clk_exp = 11'b10_11100_110_1;
    start_reset();
    repeat (18) tick();
    for (int k = 0; k < 11; k++) begin
      n_cmp++; if (ce_out[0] !== ce_exp[10-k]) begin n_err++; $display("FAIL t4_ce0 k=%0d got %b exp %b", k, ce_out[0], ce_exp[10-k]); end
      n_cmp++; if (clk_out[0] !== clk_exp[10-k]) begin n_err++; $display("FAIL t4_clk0 k=%0d got %b exp %b", k, clk_out[0], clk_exp[10-k]); end
      if (k == 0) begin
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5;
        #1;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL t4_ready_k0 got %b exp 1", cfg_ready); end
      end
      if (k == 1) begin
        cfg_div = 8'd3;
        #1;
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL t4_ready_k1 got %b exp 0", cfg_ready); end
      end
      if (k == 2) begin
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL t4_ready_k2 got %b exp 1", cfg_ready); end
      end
      if (k == 3) cfg_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_chan_range();
    logic [2:0] exp_v;
    start_reset();
    repeat (18) tick();
    for (int k = 0; k < 10; k++) begin
      if (k == 0) begin
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd7;
        #1;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL t5_oor_ready got %b exp 1", cfg_ready); end
      end
      if (k == 1) begin
        cfg_valid = 1'b0;
        n_cmp++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL t5_err_k1 got %b exp 1", cfg_err); end
        n_cmp++; if (ce_out !== 3'b000) begin n_err++; $display("FAIL t5_ce_k1 got %b exp 000", ce_out); end
      end
      if (k == 2) begin
        n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL t5_err_k2 got %b exp 0", cfg_err); end
        n_cmp++; if (ce_out !== 3'b111) begin n_err++; $display("FAIL t5_ce_k2 got %b exp 111", ce_out); end
        n_cmp++; if (clk_out !== 3'b111) begin n_err++; $display("FAIL t5_clk_k2 got %b exp 111", clk_out); end
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0;
        #1;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL t5_ready_k2 got %b exp 1", cfg_ready); end
      end
      if (k == 3) begin
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd1;
        #1;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL t5_ready_k3 got %b exp 1", cfg_ready); end
      end
      if (k == 4) cfg_valid = 1'b0;
      if (k >= 6) begin
        exp_v = ((k % 2) == 0) ? 3'b111 : 3'b101;
        n_cmp++; if (ce_out !== exp_v) begin n_err++; $display("FAIL t5_ce k=%0d got %b exp %b", k, ce_out, exp_v); end
        n_cmp++; if (clk_out !== exp_v) begin n_err++; $display("FAIL t5_clk k=%0d got %b exp %b", k, clk_out, exp_v); end
      end
      tick();
    end
  endtask

  task automatic test_reset_pending();
    logic exp_b;
    start_reset();
    repeat (18) tick();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd9;
    tick();
    cfg_valid = 1'b0;
    #1;
    n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL t6_pending got %b exp 0", cfg_ready); end
    reset = 1'b1;
    tick();
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL t6_ready got %b exp 0", ready); end
    n_cmp++; if (ce_out !== 3'b000) begin n_err++; $display("FAIL t6_ce got %b exp 000", ce_out); end
    n_cmp++; if (clk_out !== 3'b000) begin n_err++; $display("FAIL t6_clk got %b exp 000", clk_out); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL t6_cleared got %b exp 1", cfg_ready); end
    reset = 1'b0;
    repeat (18) tick();
    for (int k = 0; k < 4; k++) begin
      exp_b = ((k % 2) == 0);
      n_cmp++; if (ce_out[1] !== exp_b) begin n_err++; $display("FAIL t6_ce1 k=%0d got %b exp %b", k, ce_out[1], exp_b); end
      n_cmp++; if (clk_out[1] !== exp_b) begin n_err++; $display("FAIL t6_clk1 k=%0d got %b exp %b", k, clk_out[1], exp_b); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_lock_timing();
    test_lock_glitch();
    test_reprogram();
    test_back_to_back();
    test_chan_range();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout compared=%0d mismatched=%0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
